// File: rtl/fetch_issue_unit.sv
// -----------------------------------------------------------------------------
// fetch_issue_unit
//
// Instruction-fetch stage of the 5-stage stall pipeline. Generates the fetch PC,
// drives a synchronous instruction memory with one cycle of read latency and
// presents {instruction, pc, valid} to decode. A stall request from the stall
// control unit freezes the fetch PC and holds the decode instruction. A branch
// redirect from execute squashes wrong-path instructions and restarts fetch at
// the branch target.
//
// Ports
//   clock               in   rising-edge clock
//   reset               in   synchronous, active-low
//   stall_needed        in   hold the current decode instruction
//   branch_valid        in   redirect request from execute
//   branch_target       in   redirect byte address (low two bits forced to 0)
//   i_mem_read          out  instruction memory read strobe (high out of reset)
//   i_mem_read_address  out  current fetch PC
//   i_mem_data_in       in   read data, valid the cycle after the read
//   instruction_decode  out  instruction presented to decode
//   pc_decode           out  PC of instruction_decode
//   valid_decode        out  instruction_decode is a real (right-path) instruction
// -----------------------------------------------------------------------------
module fetch_issue_unit #(
  parameter int                      DATA_WIDTH   = 32,
  parameter int                      ADDRESS_BITS = 20,
  parameter logic [ADDRESS_BITS-1:0] RESET_PC     = '0,
  parameter logic [DATA_WIDTH-1:0]   NOP          = 32'h00000013
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    stall_needed,
  input  logic                    branch_valid,
  input  logic [ADDRESS_BITS-1:0] branch_target,
  output logic                    i_mem_read,
  output logic [ADDRESS_BITS-1:0] i_mem_read_address,
  input  logic [DATA_WIDTH-1:0]   i_mem_data_in,
  output logic [DATA_WIDTH-1:0]   instruction_decode,
  output logic [ADDRESS_BITS-1:0] pc_decode,
  output logic                    valid_decode
);

  typedef enum logic [1:0] {
    BOOT  = 2'd0,  // first cycle after reset, first read in flight
    RUN   = 2'd1,  // memory data is the decode instruction
    HOLD  = 2'd2,  // decode instruction comes from the hold register
    FLUSH = 2'd3   // wrong-path read being discarded, target read in flight
  } state_e;

  localparam logic [ADDRESS_BITS-1:0] PC_STEP    = ADDRESS_BITS'(4);
  localparam logic [ADDRESS_BITS-1:0] ALIGN_MASK = ~ADDRESS_BITS'(3);

  state_e                  state_q,       state_d;
  logic [ADDRESS_BITS-1:0] fetch_pc_q,    fetch_pc_d;
  logic [ADDRESS_BITS-1:0] pc_inflight_q, pc_inflight_d;
  logic [DATA_WIDTH-1:0]   hold_instr_q,  hold_instr_d;
  logic [ADDRESS_BITS-1:0] hold_pc_q,     hold_pc_d;

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= BOOT;
      fetch_pc_q    <= RESET_PC;
      pc_inflight_q <= '0;
      hold_instr_q  <= NOP;
      hold_pc_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      pc_inflight_q <= pc_inflight_d;
      hold_instr_q  <= hold_instr_d;
      hold_pc_q     <= hold_pc_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. Branch beats stall; stall beats advance.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    pc_inflight_d = pc_inflight_q;
    hold_instr_d  = hold_instr_q;
    hold_pc_d     = hold_pc_q;

    if (branch_valid) begin
      // The read issued this cycle is wrong path; FLUSH throws its data away.
      fetch_pc_d = branch_target & ALIGN_MASK;
      state_d    = FLUSH;
    end else begin
      unique case (state_q)
        BOOT, FLUSH: begin
          fetch_pc_d    = fetch_pc_q + PC_STEP;
          pc_inflight_d = fetch_pc_q;
          state_d       = RUN;
        end
        RUN: begin
          if (stall_needed) begin
            // Capture the instruction now: memory data moves on next cycle.
            hold_instr_d = i_mem_data_in;
            hold_pc_d    = pc_inflight_q;
            state_d      = HOLD;
          end else begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            pc_inflight_d = fetch_pc_q;
          end
        end
        HOLD: begin
          // fetch_pc was frozen, so the read of it has been repeated and its
          // data arrives right after the release cycle.
          if (!stall_needed) begin
            fetch_pc_d    = fetch_pc_q + PC_STEP;
            pc_inflight_d = fetch_pc_q;
            state_d       = RUN;
          end
        end
        default: state_d = BOOT;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Decode-side outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    instruction_decode = NOP;
    pc_decode          = '0;
    valid_decode       = 1'b0;
    if (!branch_valid) begin
      unique case (state_q)
        RUN: begin
          instruction_decode = i_mem_data_in;
          pc_decode          = pc_inflight_q;
          valid_decode       = 1'b1;
        end
        HOLD: begin
          instruction_decode = hold_instr_q;
          pc_decode          = hold_pc_q;
          valid_decode       = 1'b1;
        end
        default: begin
          instruction_decode = NOP;
          pc_decode          = '0;
          valid_decode       = 1'b0;
        end
      endcase
    end
  end

  // Reads are issued every cycle out of reset; repeats during a stall are harmless.
  assign i_mem_read         = reset;
  assign i_mem_read_address = fetch_pc_q;

endmodule

// File: tb/tb_fetch_issue_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_issue_unit
//
// Two instances of fetch_issue_unit (RESET_PC = 0 and RESET_PC = 0xFFFFC) share
// the same control inputs; each has its own memory returning {12'h0, address}.
// The reference model describes the decode stream directly: a current stream PC
// plus a pending-bubble flag. Bubbles follow reset and redirects; a valid cycle
// with stall repeats the same PC, otherwise the stream moves on by 4.
// -----------------------------------------------------------------------------
module tb_fetch_issue_unit;

  localparam logic [31:0] NOP_I = 32'h00000013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        stall_needed;
  logic        branch_valid;
  logic [19:0] branch_target;

  logic [1:0]       rd;
  logic [1:0][19:0] addr;
  logic [1:0][31:0] mdata;
  logic [1:0][31:0] instr;
  logic [1:0][19:0] pcd;
  logic [1:0]       vd;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    fetch_issue_unit #(
      .DATA_WIDTH  (32),
      .ADDRESS_BITS(20),
      .RESET_PC    ((gi == 0) ? 20'h00000 : 20'hFFFFC),
      .NOP         (NOP_I)
    ) u_dut (
      .clock             (clk),
      .reset             (reset),
      .stall_needed      (stall_needed),
      .branch_valid      (branch_valid),
      .branch_target     (branch_target),
      .i_mem_read        (rd[gi]),
      .i_mem_read_address(addr[gi]),
      .i_mem_data_in     (mdata[gi]),
      .instruction_decode(instr[gi]),
      .pc_decode         (pcd[gi]),
      .valid_decode      (vd[gi])
    );
  end

  // Synchronous instruction memories: word at A is {12'h0, A}, one-cycle latency.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rd[i]) mdata[i] <= {12'h000, addr[i]};
    end
  end

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %h, expected %h", tag, cyc, obs, exp);
    end
  endtask

  // Reference model: stream PC, pending bubble, known-after-first-reset.
  logic [19:0] m_cur [2];
  bit          m_bub [2];
  bit          m_known = 1'b0;
  logic [19:0] m_rpc [2];

  task automatic do_cycle(input bit rst, input bit br, input bit st, input logic [19:0] tgt);
    logic        ev;
    logic [19:0] epc, eaddr;
    logic [31:0] eins;
    reset         = rst;
    branch_valid  = br;
    stall_needed  = st;
    branch_target = tgt;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      check((i == 0) ? "rd0" : "rd1", {31'd0, rd[i]}, {31'd0, rst});
      if (m_known) begin
        ev    = !br && !m_bub[i];
        epc   = ev ? m_cur[i] : 20'h0;
        eins  = ev ? {12'h000, m_cur[i]} : NOP_I;
        eaddr = m_bub[i] ? m_cur[i] : m_cur[i] + 20'd4;
        check((i == 0) ? "valid0" : "valid1", {31'd0, vd[i]},    {31'd0, ev});
        check((i == 0) ? "pc0"    : "pc1",    {12'h000, pcd[i]}, {12'h000, epc});
        check((i == 0) ? "instr0" : "instr1", instr[i],          eins);
        check((i == 0) ? "addr0"  : "addr1",  {12'h000, addr[i]}, {12'h000, eaddr});
      end
    end
    $display("cyc %0d rst=%b br=%b st=%b tgt=%h | v=%b pc=%h ins=%h addr=%h | v=%b pc=%h addr=%h",
             cyc, rst, br, st, tgt, vd[0], pcd[0], instr[0], addr[0], vd[1], pcd[1], addr[1]);
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (!rst) begin
        m_cur[i] = m_rpc[i];
        m_bub[i] = 1'b1;
      end else if (br) begin
        m_cur[i] = tgt & ~20'd3;
        m_bub[i] = 1'b1;
      end else if (m_bub[i]) begin
        m_bub[i] = 1'b0;
      end else if (!st) begin
        m_cur[i] = m_cur[i] + 20'd4;
      end
    end
    if (!rst) m_known = 1'b1;
    cyc++;
    #1;
  endtask

  task automatic run(input int n, input bit rst, input bit br, input bit st, input logic [19:0] tgt);
    for (int k = 0; k < n; k++) do_cycle(rst, br, st, tgt);
  endtask

  initial begin
    m_rpc[0] = 20'h00000;
    m_rpc[1] = 20'hFFFFC;
    m_cur[0] = '0; m_cur[1] = '0;
    m_bub[0] = 1'b1; m_bub[1] = 1'b1;

    // Reset, then boot: bubble, pc 0, pc 4 (second instance wraps FFFFC -> 0).
    run(3, 1'b0, 1'b0, 1'b0, 20'h0);
    run(3, 1'b1, 1'b0, 1'b0, 20'h0);
    // Stall two cycles while pc 8 is in decode, then continue.
    run(2, 1'b1, 1'b0, 1'b1, 20'h0);
    run(3, 1'b1, 1'b0, 1'b0, 20'h0);
    // Redirect to 0x103 while pc 8 is in decode.
    run(2, 1'b0, 1'b0, 1'b0, 20'h0);
    run(3, 1'b1, 1'b0, 1'b0, 20'h0);
    run(1, 1'b1, 1'b1, 1'b0, 20'h00103);
    run(3, 1'b1, 1'b0, 1'b0, 20'h0);
    // Branch together with stall while in HOLD; stall ignored during flush.
    run(1, 1'b1, 1'b0, 1'b1, 20'h0);
    run(1, 1'b1, 1'b1, 1'b1, 20'h00202);
    run(1, 1'b1, 1'b0, 1'b1, 20'h0);
    run(3, 1'b1, 1'b0, 1'b0, 20'h0);
    // Redirect to the top of the address space: PC wraps to 0.
    run(1, 1'b1, 1'b1, 1'b0, 20'hFFFFF);
    run(4, 1'b1, 1'b0, 1'b0, 20'h0);
    // Reset while holding.
    run(2, 1'b1, 1'b0, 1'b1, 20'h0);
    run(1, 1'b0, 1'b0, 1'b1, 20'h0);
    run(1, 1'b0, 1'b0, 1'b0, 20'h0);
    run(3, 1'b1, 1'b0, 1'b0, 20'h0);

    // Randomized traffic.
    for (int k = 0; k < 2000; k++) begin
      do_cycle(($urandom_range(0, 63) != 0),
               ($urandom_range(0, 9) == 0),
               ($urandom_range(0, 2) == 0),
               20'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
